// File: rtl/cam_alloc_if.sv
// Requester-side bus of cam_alloc_ctrl. Each requester sees one req/op/key slice.
// All requesters share a single response channel.
// Handshake: requester i raises req[i] with req_op[i]/req_key[i] stable and holds it until the
// one-cycle gnt[i]; exactly one rsp_valid pulse later follows each grant, tagged with rsp_id=i.
interface cam_alloc_if #(
  parameter int DATA  = 32,
  parameter int DEPTH = 32,
  parameter int REQ   = 4
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int RID  = $clog2(REQ);

  logic [REQ-1:0]      req;
  logic [REQ-1:0]      req_op;
  logic [REQ*DATA-1:0] req_key;
  logic [REQ-1:0]      gnt;
  logic                rsp_valid;
  logic [RID-1:0]      rsp_id;
  logic                rsp_hit;
  logic [ADDR-1:0]     rsp_addr;
  logic                rsp_alloc;
  logic                rsp_evict;
  logic                rsp_err;

  modport master (
    output req, req_op, req_key,
    input  gnt, rsp_valid, rsp_id, rsp_hit, rsp_addr, rsp_alloc, rsp_evict, rsp_err
  );

  modport slave (
    input  req, req_op, req_key,
    output gnt, rsp_valid, rsp_id, rsp_hit, rsp_addr, rsp_alloc, rsp_evict, rsp_err
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Round-robin sequencer in front of one CAM read/write port pair: lookup and lookup-or-insert,
// per-entry valid tracking, lowest-free allocation with round-robin eviction, and CAM flushing.
module cam_alloc_ctrl #(
  parameter int              DATA      = 32,
  parameter int              DEPTH     = 32,
  parameter int              REQ       = 4,
  parameter logic [DATA-1:0] FLUSH_KEY = {DATA{1'b1}},
  localparam int             ADDR      = $clog2(DEPTH),
  localparam int             RID       = $clog2(REQ)
) (
  input  logic            clk,
  input  logic            reset,
  cam_alloc_if.slave      rq,
  input  logic            flush,
  output logic            busy,
  output logic            full,
  output logic [ADDR:0]   count,
  output logic            cam_re_,
  output logic [DATA-1:0] cam_rm,
  output logic [DATA-1:0] cam_rd,
  input  logic            cam_match,
  input  logic [ADDR-1:0] cam_raddr,
  output logic            cam_we_,
  output logic [DATA-1:0] cam_wm,
  output logic [DATA-1:0] cam_wd,
  output logic [ADDR-1:0] cam_waddr,
  output logic [2:0]      dbg_state
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_LOOK  = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  localparam logic [ADDR:0]   FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(DEPTH-1);

  logic [2:0]       state;
  logic [ADDR-1:0]  fptr;
  logic [ADDR-1:0]  vptr;
  logic [DEPTH-1:0] valid;
  logic [RID-1:0]   rr;
  logic             flush_pend;

  logic [RID-1:0]   cur_id;
  logic             cur_op;
  logic [DATA-1:0]  cur_key;

  logic             r_hit;
  logic [ADDR-1:0]  r_addr;
  logic             r_alloc;
  logic             r_evict;
  logic             r_err;

  // Round-robin pick: scan downward so the last hit is the first requester at or above rr.
  logic           any_req;
  logic [RID-1:0] win;
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = REQ-1; k >= 0; k--) begin
      if (rq.req[(int'(rr) + k) % REQ]) begin
        any_req = 1'b1;
        win     = RID'((int'(rr) + k) % REQ);
      end
    end
  end

  logic [DATA-1:0] win_key;
  assign win_key = rq.req_key[int'(win)*DATA +: DATA];

  logic can_grant;
  assign can_grant = reset && (state == S_IDLE) && !flush_pend && any_req;

  // Lowest-index free entry; when none is free the victim pointer supplies the address.
  logic [ADDR-1:0] free_addr;
  logic            have_free;
  always_comb begin
    free_addr = '0;
    have_free = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) begin
        have_free = 1'b1;
        free_addr = ADDR'(i);
      end
    end
  end

  logic [ADDR-1:0] wr_addr;
  assign wr_addr = have_free ? free_addr : vptr;

  logic [ADDR:0] vcount;
  always_comb begin
    vcount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vcount = vcount + {{ADDR{1'b0}}, valid[i]};
    end
  end

  logic hit;
  assign hit = cam_match & valid[cam_raddr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_INIT;
      fptr       <= '0;
      vptr       <= '0;
      valid      <= '0;
      rr         <= '0;
      flush_pend <= 1'b0;
      cur_id     <= '0;
      cur_op     <= 1'b0;
      cur_key    <= '0;
      r_hit      <= 1'b0;
      r_addr     <= '0;
      r_alloc    <= 1'b0;
      r_evict    <= 1'b0;
      r_err      <= 1'b0;
      count      <= '0;
      full       <= 1'b0;
    end else begin
      count <= vcount;
      full  <= (vcount == FULL_CNT);
      if (flush) flush_pend <= 1'b1;

      case (state)
        S_INIT, S_FLUSH: begin
          fptr <= fptr + 1'b1;
          if (fptr == LAST_IDX) state <= S_IDLE;
        end

        S_IDLE: begin
          if (flush_pend) begin
            // A pulse arriving on this very cycle must survive the clear.
            state      <= S_FLUSH;
            fptr       <= '0;
            vptr       <= '0;
            valid      <= '0;
            flush_pend <= flush;
          end else if (any_req) begin
            cur_id  <= win;
            cur_op  <= rq.req_op[win];
            cur_key <= win_key;
            rr      <= (int'(win) == REQ-1) ? '0 : win + 1'b1;
            if (win_key == FLUSH_KEY) begin
              r_hit   <= 1'b0;
              r_addr  <= '0;
              r_alloc <= 1'b0;
              r_evict <= 1'b0;
              r_err   <= 1'b1;
              state   <= S_RESP;
            end else begin
              state <= S_LOOK;
            end
          end
        end

        S_LOOK: state <= S_CMP;

        S_CMP: begin
          if (hit || !cur_op) begin
            r_hit   <= hit;
            r_addr  <= hit ? cam_raddr : '0;
            r_alloc <= 1'b0;
            r_evict <= 1'b0;
            r_err   <= 1'b0;
            state   <= S_RESP;
          end else begin
            state <= S_WRITE;
          end
        end

        S_WRITE: begin
          valid[wr_addr] <= 1'b1;
          if (!have_free) vptr <= vptr + 1'b1;
          r_hit   <= 1'b0;
          r_addr  <= wr_addr;
          r_alloc <= 1'b1;
          r_evict <= !have_free;
          r_err   <= 1'b0;
          state   <= S_RESP;
        end

        S_RESP: state <= S_IDLE;

        default: begin
          state <= S_INIT;
          fptr  <= '0;
        end
      endcase
    end
  end

  // CAM strobes and grants are masked while reset is held so a dropped op leaves no trace.
  always_comb begin
    cam_re_   = 1'b1;
    cam_rd    = '0;
    cam_we_   = 1'b1;
    cam_wd    = '0;
    cam_waddr = '0;
    rq.gnt    = '0;
    if (reset) begin
      case (state)
        S_INIT, S_FLUSH: begin
          cam_we_   = 1'b0;
          cam_wd    = FLUSH_KEY;
          cam_waddr = fptr;
        end
        S_IDLE: begin
          if (can_grant) rq.gnt[win] = 1'b1;
        end
        S_LOOK: begin
          cam_re_ = 1'b0;
          cam_rd  = cur_key;
        end
        S_WRITE: begin
          cam_we_   = 1'b0;
          cam_wd    = cur_key;
          cam_waddr = wr_addr;
        end
        default: ;
      endcase
    end
  end

  logic rsp_on;
  assign rsp_on       = reset && (state == S_RESP);
  assign rq.rsp_valid = rsp_on;
  assign rq.rsp_id    = rsp_on ? cur_id  : '0;
  assign rq.rsp_hit   = rsp_on & r_hit;
  assign rq.rsp_addr  = rsp_on ? r_addr  : '0;
  assign rq.rsp_alloc = rsp_on & r_alloc;
  assign rq.rsp_evict = rsp_on & r_evict;
  assign rq.rsp_err   = rsp_on & r_err;

  assign busy      = !reset || (state != S_IDLE);
  assign cam_rm    = '0;
  assign cam_wm    = '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed bench for cam_alloc_ctrl with a behavioural CAM, expected queues for responses,
// CAM writes/reads and status probes, and a single monitor that does all comparing.
module tb_cam_alloc_ctrl;
  localparam int DATA  = 32;
  localparam int DEPTH = 32;
  localparam int REQ   = 4;
  localparam int ADDR  = 5;
  localparam int EW    = 14;
  localparam logic [DATA-1:0] FKEY = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  cam_alloc_if #(.DATA(DATA), .DEPTH(DEPTH), .REQ(REQ)) rq ();

  logic            busy, full;
  logic [ADDR:0]   count;
  logic            cam_re_, cam_we_;
  logic [DATA-1:0] cam_rm, cam_rd, cam_wm, cam_wd;
  logic            cam_match = 1'b0;
  logic [ADDR-1:0] cam_raddr = '0;
  logic [ADDR-1:0] cam_waddr;
  logic [2:0]      dbg_state;

  cam_alloc_ctrl #(.DATA(DATA), .DEPTH(DEPTH), .REQ(REQ), .FLUSH_KEY(FKEY)) dut (
    .clk(clk), .reset(reset), .rq(rq), .flush(flush), .busy(busy), .full(full),
    .count(count), .cam_re_(cam_re_), .cam_rm(cam_rm), .cam_rd(cam_rd),
    .cam_match(cam_match), .cam_raddr(cam_raddr), .cam_we_(cam_we_), .cam_wm(cam_wm),
    .cam_wd(cam_wd), .cam_waddr(cam_waddr), .dbg_state(dbg_state)
  );

  // Behavioural CAM: match/addr one cycle after the read strobe, lowest index wins.
  logic [DATA-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!cam_we_) mem[cam_waddr] <= cam_wd;
    cam_match <= 1'b0;
    if (!cam_re_) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (mem[i] == cam_rd) begin
          cam_match <= 1'b1;
          cam_raddr <= ADDR'(i);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {lat[2:0], id[1:0], hit, addr[4:0], alloc, evict, err}
  logic [EW-1:0]        exp_q[$];
  logic [ADDR+DATA-1:0] wr_q[$];
  logic [DATA-1:0]      rd_q[$];
  logic [35:0]          chk_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  logic to_flag = 1'b0;

  logic [EW-1:0]        got, want;
  logic [3:0]           eg;
  logic [ADDR+DATA-1:0] wgot, wwant;
  logic [35:0]          ck;
  logic [31:0]          act;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rq.gnt != '0) begin
      gnt_cyc = cyc;
      eg = (exp_q.size() != 0) ? (4'b0001 << exp_q[0][10:9]) : 4'b0000;
      n_vec++;
      if (rq.gnt !== eg) begin
        n_err++;
        $display("FAIL gnt: got %b want %b (t=%0t)", rq.gnt, eg, $time);
      end
    end
    if (rq.rsp_valid) begin
      got = {3'(cyc - gnt_cyc), rq.rsp_id, rq.rsp_hit, rq.rsp_addr,
             rq.rsp_alloc, rq.rsp_evict, rq.rsp_err};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rsp {lat,id,hit,addr,alloc,evict,err}: got %h want %h (t=%0t)", got, want, $time);
      end
    end
    if (!cam_we_) begin
      wgot  = {cam_waddr, cam_wd};
      wwant = (wr_q.size() != 0) ? wr_q.pop_front() : '0;
      n_vec++;
      if (wgot !== wwant) begin
        n_err++;
        $display("FAIL cam_write {waddr,wd}: got %h want %h (t=%0t)", wgot, wwant, $time);
      end
    end
    if (!cam_re_) begin
      act = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
      n_vec++;
      if (cam_rd !== act) begin
        n_err++;
        $display("FAIL cam_read rd: got %h want %h (t=%0t)", cam_rd, act, $time);
      end
    end
    while (chk_q.size() != 0) begin
      ck = chk_q.pop_front();
      case (ck[35:32])
        4'd0:    act = 32'(busy);
        4'd1:    act = 32'(count);
        4'd2:    act = 32'(full);
        4'd3:    act = 32'(to_flag);
        4'd4:    act = 32'(exp_q.size());
        4'd5:    act = 32'(wr_q.size());
        default: act = 32'(rd_q.size());
      endcase
      n_vec++;
      if (act !== ck[31:0]) begin
        n_err++;
        $display("FAIL probe%0d (0=busy 1=count 2=full 3=timeout 4-6=queue): got %0d want %0d (t=%0t)",
                 ck[35:32], act, ck[31:0], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [3:0] kind, input logic [31:0] v);
    chk_q.push_back({kind, v});
  endtask

  task automatic push_flush_writes();
    for (int i = 0; i < DEPTH; i++) wr_q.push_back({ADDR'(i), FKEY});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    rq.req = '0;
    wr_q.delete();
    tick();
    probe(0, 1); probe(1, 0); probe(2, 0);
    tick();
    reset = 1'b1;
    push_flush_writes();
    for (int i = 0; i < DEPTH; i++) begin
      probe(0, 1);
      tick();
    end
    probe(0, 0); probe(1, 0); probe(2, 0);
  endtask

  task automatic setup(input int id, input logic op, input logic [DATA-1:0] key,
                       input logic hit, input int addr, input logic alloc, input logic evict);
    logic       err;
    logic [2:0] lat;
    err = (key == FKEY);
    lat = err ? 3'd1 : (alloc ? 3'd4 : 3'd3);
    exp_q.push_back({lat, 2'(id), hit, 5'(addr), alloc, evict, err});
    if (!err) rd_q.push_back(key);
    if (alloc) wr_q.push_back({5'(addr), key});
    rq.req_op[id] = op;
    rq.req_key[id*DATA +: DATA] = key;
  endtask

  task automatic timeout();
    to_flag = 1'b1;
    probe(3, 0);
  endtask

  task automatic wait_rsp();
    int t;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (t == 40) timeout();
    tick();
  endtask

  // Raise every request in mask together; drop each one the cycle after its grant.
  task automatic run(input logic [3:0] mask, input logic fl);
    int t;
    logic [3:0] g;
    rq.req = mask;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rq.gnt != '0) begin
        g = rq.gnt;
        tick();
        rq.req = rq.req & ~g;
        if (fl) begin
          flush = 1'b1;
          push_flush_writes();
          tick();
          flush = 1'b0;
        end
        if (rq.req == '0) break;
      end
    end
    if (t == 200) begin
      timeout();
      rq.req = '0;
    end
    wait_rsp();
  endtask

  task automatic issue(input int id, input logic op, input logic [DATA-1:0] key,
                       input logic hit, input int addr, input logic alloc, input logic evict);
    setup(id, op, key, hit, addr, alloc, evict);
    run(4'(1 << id), 1'b0);
  endtask

  task automatic wait_writes_done();
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (wr_q.size() == 0) break;
    end
    if (t == 100) timeout();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rq.req = '0;
    rq.req_op = '0;
    rq.req_key = '0;

    do_reset();

    // single requester insert / re-insert / lookup miss
    issue(0, 1'b1, 32'h100, 1'b0, 0, 1'b1, 1'b0);
    issue(0, 1'b1, 32'h100, 1'b1, 0, 1'b0, 1'b0);
    issue(3, 1'b0, 32'h200, 1'b0, 0, 1'b0, 1'b0);
    probe(1, 1); probe(2, 0);

    // four simultaneous inserts from rr=0, then req0+req1
    do_reset();
    for (int i = 0; i < 4; i++) setup(i, 1'b1, 32'h100 << i, 1'b0, i, 1'b1, 1'b0);
    run(4'b1111, 1'b0);
    probe(1, 4);
    setup(0, 1'b0, 32'h100, 1'b1, 0, 1'b0, 1'b0);
    setup(1, 1'b0, 32'h200, 1'b1, 1, 1'b0, 1'b0);
    run(4'b0011, 1'b0);

    // fill to full, then round-robin eviction
    for (int i = 0; i < 28; i++) issue(i % 4, 1'b1, 32'h1000 + i, 1'b0, 4 + i, 1'b1, 1'b0);
    probe(1, 32); probe(2, 1);
    issue(0, 1'b1, 32'h9999, 1'b0, 0, 1'b1, 1'b1);
    issue(1, 1'b1, 32'hAAAA, 1'b0, 1, 1'b1, 1'b1);
    probe(1, 32); probe(2, 1);
    issue(2, 1'b0, 32'h100, 1'b0, 0, 1'b0, 1'b0);
    issue(3, 1'b0, 32'h9999, 1'b1, 0, 1'b0, 1'b0);
    issue(0, 1'b0, 32'h1000, 1'b1, 4, 1'b0, 1'b0);

    // reserved key: immediate error, no CAM traffic
    issue(2, 1'b1, FKEY, 1'b0, 0, 1'b0, 1'b0);
    probe(1, 32);

    // flush while an evicting insert is in flight
    setup(1, 1'b1, 32'h5555, 1'b0, 2, 1'b1, 1'b1);
    run(4'b0010, 1'b1);
    wait_writes_done();
    tick();
    probe(0, 0); probe(1, 0); probe(2, 0);
    issue(2, 1'b0, 32'h5555, 1'b0, 0, 1'b0, 1'b0);
    issue(3, 1'b1, 32'h7777, 1'b0, 0, 1'b1, 1'b0);
    tick();
    probe(1, 1);

    // reset in the middle of a flush pass restarts INIT at entry 0
    flush = 1'b1;
    push_flush_writes();
    tick();
    flush = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    probe(0, 1);
    do_reset();
    issue(1, 1'b0, 32'h7777, 1'b0, 0, 1'b0, 1'b0);

    probe(4, 0); probe(5, 0); probe(6, 0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
